// File: rtl/read_pointer_empty_block_pkg.sv
// Shared FIFO package: default pointer sizing and Gray/binary conversion.
// Used by both the read-side and write-side pointer blocks.
package read_pointer_empty_block_pkg;

    localparam int ADDR_SIZE_DEFAULT = 3;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/read_pointer_empty_block_g2b.sv
// Gray-to-binary converter for the synchronized write pointer.
// Only built with READ_LEVEL_EN defined.
`ifdef READ_LEVEL_EN
module gray_to_binary_block
    import read_pointer_empty_block_pkg::*;
#(
    parameter int addr_size = ADDR_SIZE_DEFAULT
) (
    input  logic [addr_size:0] gray_i,
    output logic [addr_size:0] bin_o
);

    logic [31:0] bin32;

    always_comb begin
        bin32 = gray2bin(32'(gray_i));
        bin_o = bin32[addr_size:0];
    end

endmodule
`endif

// File: rtl/read_pointer_empty_block.sv
// Read-side pointer, empty flag and sticky underflow for an async FIFO.
// READ_LEVEL_EN adds read_level_o / almost_empty_o.
module read_pointer_empty_block
    import read_pointer_empty_block_pkg::*;
#(
    parameter int addr_size              = ADDR_SIZE_DEFAULT,
    parameter int almost_empty_threshold = 1
) (
    input  logic                 read_clock_i,
    input  logic                 read_reset_n_i,
    input  logic                 read_en_i,
    input  logic [addr_size:0]   write_to_read_pointer_i,
    input  logic                 underflow_clear_i,
    output logic [addr_size-1:0] read_address_o,
    output logic [addr_size:0]   read_pointer_o,
    output logic                 empty_o,
    output logic                 underflow_o
`ifdef READ_LEVEL_EN
    ,
    output logic [addr_size:0]   read_level_o,
    output logic                 almost_empty_o
`endif
);

    localparam int PW = addr_size + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic          empty_q, empty_d;
    logic          underflow_q, underflow_d;
    logic          read_accept;
    logic [31:0]   gray32;

    always_comb begin
        read_accept = read_en_i & ~empty_q;
        rbin_d      = rbin_q + PW'(read_accept);
        gray32      = bin2gray(32'(rbin_d));
        rgray_d     = gray32[PW-1:0];
        // Compare the post-read pointer so empty asserts right after the last read.
        empty_d     = (rgray_d == write_to_read_pointer_i);
        underflow_d = (read_en_i & empty_q) | (underflow_q & ~underflow_clear_i);
    end

    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

    assign read_address_o = rbin_q[addr_size-1:0];
    assign read_pointer_o = rgray_q;
    assign empty_o        = empty_q;
    assign underflow_o    = underflow_q;

`ifdef READ_LEVEL_EN
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_q, level_d;
    logic          almost_empty_q, almost_empty_d;

    gray_to_binary_block #(
        .addr_size(addr_size)
    ) u_g2b (
        .gray_i(write_to_read_pointer_i),
        .bin_o (wbin)
    );

    always_comb begin
        level_d        = wbin - rbin_d;
        almost_empty_d = (level_d <= PW'(almost_empty_threshold));
    end

    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            level_q        <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            level_q        <= level_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign read_level_o   = level_q;
    assign almost_empty_o = almost_empty_q;
`endif

endmodule

// File: doc/read_pointer_empty_block.md
READ_POINTER_EMPTY_BLOCK -- requirements
Module: read_pointer_empty_block

Interface
REQ-001 SHALL have parameter addr_size, default 3, giving a FIFO depth of 2^addr_size entries; pointers are addr_size+1 bits wide.
REQ-002 SHALL have parameter almost_empty_threshold, default 1, giving the level at or below which almost_empty_o asserts.
REQ-003 SHALL have port read_clock_i, input, 1 bit: the single read-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port read_reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port read_en_i, input, 1 bit: read request from the consumer.
REQ-006 SHALL have port write_to_read_pointer_i, input, addr_size+1 bits: Gray-coded write pointer, already synchronized into the read domain.
REQ-007 SHALL have port read_address_o, output, addr_size bits: binary read address to the FIFO memory.
REQ-008 SHALL have port read_pointer_o, output, addr_size+1 bits: registered Gray read pointer, sent to the write domain.
REQ-009 SHALL have port empty_o, output, 1 bit: registered FIFO-empty flag.
REQ-010 SHALL have port underflow_o, output, 1 bit: sticky read-while-empty flag.
REQ-011 SHALL have port underflow_clear_i, input, 1 bit: clears underflow_o.
REQ-012 SHALL have port read_level_o, output, addr_size+1 bits, present only with READ_LEVEL_EN: occupancy seen by the read side.
REQ-013 SHALL have port almost_empty_o, output, 1 bit, present only with READ_LEVEL_EN.

Function
REQ-014 SHALL keep a binary pointer rbin (addr_size+1 bits); read_accept = read_en_i & ~empty_o; rbin_next = rbin + read_accept, wrapping modulo 2^(addr_size+1).
REQ-015 SHALL compute rgray_next = (rbin_next >> 1) ^ rbin_next, and register rbin_next and rgray_next on every clock; read_pointer_o = registered Gray value.
REQ-016 SHALL drive read_address_o = rbin[addr_size-1:0] (the registered value); data at that address is valid while empty_o = 0.
REQ-017 SHALL register empty_o <= (rgray_next == write_to_read_pointer_i); empty therefore deasserts one read clock after the synchronized pointer differs, and asserts in the cycle after the last accepted read.
REQ-018 SHALL ignore read_en_i while empty_o = 1: the pointer and address stay unchanged.
REQ-019 SHALL set underflow_o on the clock after read_en_i = 1 with empty_o = 1; underflow_o holds until underflow_clear_i = 1; when set and clear occur together, set wins.
REQ-020 SHALL treat a simultaneous read accept and write-pointer change as independent: the empty compare uses rgray_next against the current synchronized pointer.

Reset
REQ-021 SHALL, on read_reset_n_i = 0 and asynchronously to the clock, force rbin = 0, read_pointer_o = 0, read_address_o = 0, empty_o = 1, underflow_o = 0, read_level_o = 0, and almost_empty_o = 1.
REQ-022 SHALL, on a reset asserted mid-operation, discard the pending read; the first read after release is from address 0.

Configuration
REQ-023 SHALL compile in, with macro READ_LEVEL_EN defined, a gray-to-binary conversion of write_to_read_pointer_i to wbin, a registered read_level_o <= wbin - rbin_next (mod 2^(addr_size+1)), and a registered almost_empty_o <= (level <= almost_empty_threshold).
REQ-024 SHALL, without READ_LEVEL_EN, omit read_level_o, almost_empty_o and the converter; all other behaviour is identical.

Structure
REQ-025 SHALL place the Gray/binary conversion functions and the default addr_size constant in the shared FIFO package used by the write-side blocks.
REQ-026 SHALL instantiate one sub-module, gray_to_binary_block (parameter addr_size), only under READ_LEVEL_EN.

Verification (addr_size = 3, threshold = 1)
REQ-027 SHALL cover reset: apply reset, then release -> empty_o = 1, read_pointer_o = 0000, read_address_o = 000, underflow_o = 0; assert reset mid-stream -> all outputs return to reset values immediately.
REQ-028 SHALL cover fill then drain: write_to_read_pointer_i = 0010 (binary 3) -> empty_o = 0 next clock and read_level_o = 3; three reads -> addresses 0, 1, 2, then empty_o = 1 with read_pointer_o = 0010, and almost_empty_o = 1 once the level is 1.
REQ-029 SHALL cover underflow: read_en_i = 1 while empty -> underflow_o = 1 next clock and the pointer is unchanged; underflow_clear_i together with another empty read -> underflow_o stays 1; clear alone -> 0.
REQ-030 SHALL cover wrap-around: run 16 write/read pairs -> rbin goes 1111 to 0000, the Gray pointer goes 1000 to 0000, and empty_o is correct across the wrap.
REQ-031 SHALL cover a full FIFO: write pointer Gray 1100 (binary 8) with rbin = 0 -> read_level_o = 8, empty_o = 0, and eight reads succeed.
